// File: rtl/iir_sample_server_pkg.sv
// rtl/iir_sample_server_pkg.sv - shared types and constants for the IIR sample server
// Contents: FSM state enum, address/sample/length widths, default DEPTH and TMO.
package iir_sample_server_pkg;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = ADDR_W + 1;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_TMO   = 8;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_FIN = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/iir_sample_server_if.sv
// rtl/iir_sample_server_if.sv - filter-side bus between the sample server and the IIR filter
// Signals: filt_rst, data_done, DIn (server -> filter);
//          load, RAddr, WEN, WAddr, Yn, Finish (filter -> server).
// Modports: master = filter side, slave = sample server side.
interface iir_sample_server_if;
  import iir_sample_server_pkg::*;

  logic                     filt_rst;
  logic                     load;
  logic        [ADDR_W-1:0] RAddr;
  logic signed [DATA_W-1:0] DIn;
  logic                     WEN;
  logic        [ADDR_W-1:0] WAddr;
  logic signed [DATA_W-1:0] Yn;
  logic                     data_done;
  logic                     Finish;

  modport master (
    output load, RAddr, WEN, WAddr, Yn, Finish,
    input  filt_rst, DIn, data_done
  );

  modport slave (
    input  load, RAddr, WEN, WAddr, Yn, Finish,
    output filt_rst, DIn, data_done
  );
endinterface

// File: rtl/iir_sample_ram.sv
// rtl/iir_sample_ram.sv - word memory with one synchronous write port and one asynchronous read port
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out (combinational read).
module iir_sample_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/iir_sample_server.sv
// rtl/iir_sample_server.sv - feeds stored samples to an IIR filter and captures its results
// Ports: clk, rst (async active-low); host_we/host_addr/host_wdata sample load;
//        host_len/start run control; filt (slave modport) filter bus;
//        rd_addr/rd_data result readback; busy/done/err_tmo status.
// Option GOLDEN_CHECK_EN: adds host_gsel (golden memory write select) and
//        mism_cnt (saturating count of results differing from golden).
module iir_sample_server
  import iir_sample_server_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TMO   = DEF_TMO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
`ifdef GOLDEN_CHECK_EN
  input  logic              host_gsel,
  output logic [15:0]       mism_cnt,
`endif
  input  logic [LEN_W-1:0]  host_len,
  input  logic              start,
  iir_sample_server_if.slave filt,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err_tmo
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic               data_done_q, data_done_d;
  logic               err_tmo_q, err_tmo_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;

  logic [DATA_W-1:0]  smp_rdata, res_rdata;
  logic               smp_we, res_we;

  // Address qualifiers; the extra MSB keeps the compare exact for len up to 2^20.
  logic start_ok, host_in, raddr_in, raddr_end, waddr_in, rdaddr_in, tmo_hit, leave_done;
  assign start_ok   = start && (host_len != '0) && (host_len <= DEPTH_L);
  assign host_in    = {1'b0, host_addr} < DEPTH_L;
  assign raddr_in   = {1'b0, filt.RAddr} < len_q;
  assign raddr_end  = {1'b0, filt.RAddr} == len_q;
  assign waddr_in   = {1'b0, filt.WAddr} < len_q;
  assign rdaddr_in  = {1'b0, rd_addr} < len_q;
  assign tmo_hit    = tmo_cnt_q == TW'(TMO - 1);
  assign leave_done = (state_q == ST_DONE) && start;

`ifdef GOLDEN_CHECK_EN
  logic              gold_we;
  logic [DATA_W-1:0] gold_rdata;
  logic [15:0]       mism_cnt_q, mism_cnt_d;
  assign smp_we  = (state_q == ST_LOAD) && host_we && host_in && !host_gsel;
  assign gold_we = (state_q == ST_LOAD) && host_we && host_in && host_gsel;
`else
  assign smp_we  = (state_q == ST_LOAD) && host_we && host_in;
`endif
  // Result writes are accepted in every state so a late final result still lands.
  assign res_we = filt.WEN && waddr_in;

  iir_sample_ram #(.AW(AW), .DW(DATA_W)) u_sample_ram (
    .clk   (clk),
    .we    (smp_we),
    .waddr (host_addr[AW-1:0]),
    .wdata (host_wdata),
    .raddr (filt.RAddr[AW-1:0]),
    .rdata (smp_rdata)
  );

  iir_sample_ram #(.AW(AW), .DW(DATA_W)) u_result_ram (
    .clk   (clk),
    .we    (res_we),
    .waddr (filt.WAddr[AW-1:0]),
    .wdata (filt.Yn),
    .raddr (rd_addr[AW-1:0]),
    .rdata (res_rdata)
  );

`ifdef GOLDEN_CHECK_EN
  iir_sample_ram #(.AW(AW), .DW(DATA_W)) u_golden_ram (
    .clk   (clk),
    .we    (gold_we),
    .waddr (host_addr[AW-1:0]),
    .wdata (host_wdata),
    .raddr (filt.WAddr[AW-1:0]),
    .rdata (gold_rdata)
  );

  always_comb begin
    mism_cnt_d = mism_cnt_q;
    if (leave_done) begin
      mism_cnt_d = '0;
    end else if (res_we && (gold_rdata != filt.Yn) && (mism_cnt_q != 16'hFFFF)) begin
      mism_cnt_d = mism_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mism_cnt_q <= '0;
    else      mism_cnt_q <= mism_cnt_d;
  end

  assign mism_cnt = mism_cnt_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_LOAD;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:     if (start_ok) state_d = ST_RUN;
      ST_RUN:      if (raddr_end) state_d = ST_WAIT_FIN;
      ST_WAIT_FIN: if (filt.Finish || tmo_hit) state_d = ST_DONE;
      ST_DONE:     if (start) state_d = ST_LOAD;
      default:     state_d = ST_LOAD;
    endcase
  end

  // Datapath next-state
  always_comb begin
    len_d       = len_q;
    tmo_cnt_d   = '0;
    data_done_d = data_done_q;
    err_tmo_d   = err_tmo_q;
    rd_data_d   = rdaddr_in ? res_rdata : '0;

    if ((state_q == ST_LOAD) && start_ok) len_d = host_len;
    if (state_q == ST_WAIT_FIN) tmo_cnt_d = tmo_cnt_q + TW'(1);

    if (leave_done) begin
      data_done_d = 1'b0;
      err_tmo_d   = 1'b0;
    end else begin
      if ((state_q == ST_RUN) && raddr_end) data_done_d = 1'b1;
      // Finish in the last allowed cycle still wins over the timeout.
      if ((state_q == ST_WAIT_FIN) && !filt.Finish && tmo_hit) err_tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      tmo_cnt_q   <= '0;
      data_done_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      len_q       <= len_d;
      tmo_cnt_q   <= tmo_cnt_d;
      data_done_q <= data_done_d;
      err_tmo_q   <= err_tmo_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Outputs
  always_comb begin
    busy           = (state_q == ST_RUN) || (state_q == ST_WAIT_FIN);
    done           = (state_q == ST_DONE);
    filt.filt_rst  = !busy;
    filt.data_done = data_done_q;
    filt.DIn       = (filt.load && raddr_in) ? smp_rdata : '0;
    err_tmo        = err_tmo_q;
    rd_data        = rd_data_q;
  end
endmodule

// File: doc/iir_sample_server.md
IIR_SAMPLE_SERVER -- requirements
Module: iir_sample_server

Interface
REQ-001 Parameter DEPTH, default 1024: sample/result memory depth in words (power of two, at most 2^20).
REQ-002 Parameter TMO, default 8: maximum cycles from data_done to Finish.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 host_we, host_addr, host_wdata  in  1/20/16  host write of sample word; only while in LOAD.
REQ-006 host_len  in  21  number of samples in the run; latched at start.
REQ-007 start  in  1  one-cycle pulse: begin run.
REQ-008 filt_rst  out  1  active-high reset driven to the filter.
REQ-009 load  in  1  filter read-enable.
REQ-010 RAddr  in  20  filter read address.
REQ-011 DIn  out  16 signed  sample for RAddr.
REQ-012 WEN, WAddr, Yn  in  1/20/16 signed  filter result write.
REQ-013 data_done  out  1  end-of-input indication to the filter.
REQ-014 Finish  in  1  filter completion acknowledge.
REQ-015 rd_addr  in  20; rd_data  out  16  result readback.
REQ-016 busy, done, err_tmo  out  1 each  status.

Function
REQ-017 FSM states LOAD, RUN, WAIT_FIN, DONE; reset state LOAD.
REQ-018 LOAD: filt_rst=1; each host_we cycle writes host_wdata to sample[host_addr]; host_addr >= DEPTH ignored.
REQ-019 LOAD -> RUN on start with 0 < host_len <= DEPTH; start with host_len == 0 or host_len > DEPTH is ignored.
REQ-020 RUN: filt_rst=0 starting the cycle after start; busy=1 in RUN and WAIT_FIN.
REQ-021 DIn is combinational: sample[RAddr] when load=1 and RAddr < len, else 0.
REQ-022 On any clock edge with WEN=1 and WAddr < len, Yn is written to result[WAddr]; writes with WAddr >= len are dropped and do not fault.
REQ-023 data_done is registered and asserts the cycle after RAddr == len is sampled in RUN; it holds high until LOAD is re-entered.
REQ-024 Writes remain accepted in WAIT_FIN, so the final result (WAddr = len-1) is captured.
REQ-025 RUN -> WAIT_FIN when data_done asserts.
REQ-026 WAIT_FIN -> DONE on Finish=1.
REQ-027 If Finish is not seen within TMO cycles, err_tmo sets (sticky) and the FSM enters DONE.
REQ-028 DONE: filt_rst=1, done=1; rd_data = result[rd_addr] with 1-cycle registered latency; reads beyond len return 0.
REQ-029 DONE -> LOAD on start; this clears done, err_tmo, and data_done; sample memory is retained.
REQ-030 start outside LOAD and DONE is ignored.
REQ-031 Finish outside WAIT_FIN is ignored.

Reset
REQ-032 Asynchronous reset sets state=LOAD, filt_rst=1, data_done=0, busy=0, done=0, err_tmo=0, rd_data=0, len=0, and clears all counters.
REQ-033 Reset asserted mid-run aborts the run immediately and holds filt_rst=1.
REQ-034 Memory contents are undefined after reset.

Configuration
REQ-035 With GOLDEN_CHECK_EN defined: a golden memory is host-writable in LOAD via host_gsel=1, each captured result is compared to golden[WAddr], output mism_cnt (16 bits, saturating) counts mismatches, and the count clears on LOAD entry.
REQ-036 Without GOLDEN_CHECK_EN: the golden memory, host_gsel, and mism_cnt are absent.

Structure
REQ-037 A shared package holds the FSM state enum, the address width (20), the sample width (16), and the default DEPTH and TMO.
REQ-038 One sub-module, iir_sample_ram (1 write port, 1 asynchronous read port), is instantiated for the sample, result, and golden memories.

Verification
REQ-039 Load 4 samples {100,-200,300,-400}, len=4, start -> DIn equals each sample at RAddr 0..3; data_done rises the cycle after RAddr=4.
REQ-040 Filter model writes Yn=WAddr*3 for 0..3 -> in DONE, rd_addr=2 gives rd_data=6 one cycle later.
REQ-041 Finish withheld after data_done -> err_tmo=1 and done=1 exactly TMO cycles later.
REQ-042 start with host_len=0 -> state stays LOAD and filt_rst stays 1.
REQ-043 Reset pulsed mid-RUN -> filt_rst=1, data_done=0, state LOAD on the next edge.
REQ-044 With GOLDEN_CHECK_EN defined, golden={0,3,7,9} against results {0,3,6,9} -> mism_cnt=1.
